// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ upstream requesters, the arbiter and one
// downstream consumer. The slave view is the arbiter's view: it takes
// requests and produces the merged downstream stream. The master view is
// the environment that drives the requests and consumes the output.
interface handshake_rr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]            s_vld;
    logic [NUM_REQ-1:0]            s_rdy;
    logic [DATA_WIDTH-1:0]         m_data;
    logic                          m_vld;
    logic                          m_rdy;

    modport slave (
        input  s_data,
        input  s_vld,
        input  m_rdy,
        output s_rdy,
        output m_data,
        output m_vld
    );

    modport master (
        output s_data,
        output s_vld,
        output m_rdy,
        input  s_rdy,
        input  m_data,
        input  m_vld
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding a one-entry registered
// output stage. A requester that wins arbitration keeps the channel for up to
// MAX_BURST consecutive beats, or until it drops s_vld; the search pointer
// then moves past it so every requester gets its turn.
module handshake_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_rr_arbiter_if.slave bus,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   m_vld_q, m_vld_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;

    logic                   load_en;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic [NUM_REQ-1:0]     s_rdy_c;
    logic                   xfer;
    logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];

    // Split the flat payload bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data[gi] = bus.s_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Requester index after i, wrapping from NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // The output register can take a new beat when empty or being drained.
    assign load_en = !m_vld_q || bus.m_rdy;

    // Round-robin search: first valid requester starting at ptr, modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && bus.s_vld[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The requester that may transfer this cycle: the burst owner while
    // locked, otherwise the arbitration winner.
    assign sel_idx = (state_q == BURST) ? owner_q : win_idx;

    // Ready goes to at most one requester and is held off during reset.
    always_comb begin
        s_rdy_c = '0;
        if (!rst) begin
            if (state_q == BURST) begin
                s_rdy_c[owner_q] = load_en;
            end else if (win_found) begin
                s_rdy_c[win_idx] = load_en;
            end
        end
    end

    assign bus.s_rdy = s_rdy_c;
    assign xfer      = |(bus.s_vld & s_rdy_c);

    // Next-state logic: output stage refill, burst accounting, pointer advance.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        m_vld_d    = m_vld_q;
        m_data_d   = m_data_q;

        // With a stalled output nothing moves; everything below needs load_en.
        if (load_en) begin
            m_vld_d = xfer;
            if (xfer) begin
                m_data_d = req_data[sel_idx];
            end

            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        owner_d    = win_idx;
                        grant_d    = win_idx;
                        beat_cnt_d = CNT_W'(1);
                        if (MAX_BURST == 1) begin
                            ptr_d = next_idx(win_idx);
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                            state_d = IDLE;
                            ptr_d   = next_idx(owner_q);
                        end
                    end else begin
                        // Owner has dropped s_vld: give up the lock. This
                        // costs one bubble since nobody else was ready.
                        state_d = IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            m_vld_q    <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            m_vld_q    <= m_vld_d;
            m_data_q   <= m_data_d;
        end
    end

    assign bus.m_vld  = m_vld_q;
    assign bus.m_data = m_data_q;
    assign grant_idx  = grant_q;
    assign busy       = (state_q == BURST) || m_vld_q;

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
Shares one downstream vld/rdy/data handshake channel between NUM_REQ upstream requesters using round-robin arbitration with bounded burst lock. It sits between several master-side handshake interfaces and a single slave-side interface, for example in front of the DUT's single input channel. The output is a one-entry registered pipeline stage, so there is no combinational path from m_rdy to s_rdy other than through load_en.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
DATA_WIDTH, 32, payload width per beat
MAX_BURST, 4, maximum consecutive beats granted to one requester before re-arbitration (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
s_data  input  NUM_REQ*DATA_WIDTH  requester payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_vld  input  NUM_REQ  per-requester valid
s_rdy  output  NUM_REQ  per-requester ready; one-hot or zero
m_data  output  DATA_WIDTH  registered payload to downstream
m_vld  output  1  registered valid to downstream
m_rdy  input  1  downstream ready
grant_idx  output  $clog2(NUM_REQ)  index of the current or last owner
busy  output  1  state==BURST or m_vld

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_vld=0, m_data=0, state=IDLE, ptr=0, owner=0, beat_cnt=0, grant_idx=0.
  - s_rdy is forced to 0 while rst=1.
- load_en = !m_vld || m_rdy.
- Transfer on requester i when s_vld[i] && s_rdy[i].
  - Accepted data is loaded into m_data and m_vld=1 on the next edge (latency 1 cycle).
  - With m_rdy held high, throughput is 1 beat per cycle.
- If m_vld && !m_rdy:
  - m_data and m_vld hold.
  - All s_rdy=0.
  - state, beat_cnt and ptr are unchanged.
- If load_en && no transfer: m_vld goes to 0 on the next edge.
- Requester obligation: s_data and s_vld are stable while s_vld && !s_rdy. The block never withdraws m_vld before m_rdy.
- FSM IDLE:
  - winner = first i with s_vld[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - s_rdy[winner]=load_en.
  - On transfer: owner<=winner, grant_idx<=winner, beat_cnt<=1.
    - MAX_BURST==1: stay IDLE, ptr<=(winner+1)%NUM_REQ.
    - Otherwise go to BURST.
  - No s_vld: stay IDLE, ptr unchanged.
- FSM BURST:
  - Only s_rdy[owner]=load_en; all others 0.
  - On transfer: beat_cnt<=beat_cnt+1.
    - If beat_cnt+1==MAX_BURST: go to IDLE, ptr<=(owner+1)%NUM_REQ.
  - If load_en && !s_vld[owner]: release. Go to IDLE, ptr<=(owner+1)%NUM_REQ, no transfer this cycle (one bubble).
  - If !load_en: hold.
- ptr wraps from NUM_REQ-1 to 0.
- beat_cnt width is $clog2(MAX_BURST+1) and never exceeds MAX_BURST.
- Simultaneous requests in IDLE: exactly one winner per the rule above. No requester is starved; the worst-case wait is (NUM_REQ-1)*MAX_BURST beats plus one release bubble per requester.
- Reset mid-burst:
  - The in-flight registered beat is dropped (m_vld=0).
  - The burst is abandoned.
  - The next arbitration starts from ptr=0.

Test Plan:
1. NUM_REQ=2, MAX_BURST=4, m_rdy=1; req0 presents 0xA0,0xA1,0xA2 on consecutive cycles, then drops s_vld -> m_data=0xA0,0xA1,0xA2 on the three cycles after each accept; then one bubble with s_rdy=0; FSM returns to IDLE with ptr=1.
2. req0 and req1 both continuously valid, data = requester id plus sequence number, m_rdy=1 -> output order is 0x00..0x03 from req0, 0x10..0x13 from req1, then 0x04.. from req0; grant_idx toggles every 4 beats; no bubbles at grant change.
3. Backpressure: m_vld=1 with m_data=0xA1, m_rdy=0 for 5 cycles -> m_data stays 0xA1, s_rdy=2'b00, beat_cnt constant; m_rdy=1 -> 0xA2 is accepted that cycle and appears next cycle.
4. Fairness: ptr=0, req0 sends 2 beats, then req0 and req1 assert together after the release -> req1 is granted first.
5. NUM_REQ=3, only req2 valid, MAX_BURST=1 -> grant_idx=2 every beat, ptr wraps to 0 after each beat, one beat per cycle.
6. rst pulsed for 1 cycle during req1's 3rd beat -> next cycle m_vld=0, s_rdy=0, grant_idx=0, busy=0; then req0 and req1 both valid -> req0 is granted first.
